global_pool_engine: RTL
=======================

Name: global_pool_engine

Overview:
Parametrised global pooling stage for the CNN tail. It consumes one pixel beat per handshake, each beat carrying all CHANNELS FP32 values. Over IMG_WIDTH*IMG_HEIGHT beats it reduces each channel to one FP32 result: average (sum scaled by RECIP) or maximum, selected per frame. It adds ready/valid backpressure, frame-length checking and max mode, and feeds the classifier FC layer.

Parameters:
DATA_WIDTH, 32, element width; only 32 (IEEE-754 single) is supported.
CHANNELS, 7, channels per beat.
IMG_WIDTH, 44, pixels per row.
IMG_HEIGHT, 44, rows per frame.
RECIP, 32'h3A0767AB, FP32 value of 1/(IMG_WIDTH*IMG_HEIGHT), used in avg mode.
N (localparam), IMG_WIDTH*IMG_HEIGHT, beats per frame.
CNT_W (localparam), clog2(N+1), beat counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
mode  in  1  0 = average, 1 = max; sampled on the first beat of each frame.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
in_data  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*32+31 : c*32].
in_last  in  1  source marks the final beat of a frame; checked only.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  CHANNELS*DATA_WIDTH  per-channel result, same packing as in_data.
frame_err  out  1  one-cycle pulse on in_last mismatch.

Behaviour:
- States: ACCUM, SCALE, OUTPUT. Reset state is ACCUM.
- Reset values: cnt=0, acc (CHANNELS x 32) = 0, mode_q=0, out_valid=0, frame_err=0.
- in_ready = (state==ACCUM) && rst. out_valid = (state==OUTPUT). out_data = acc.
- A beat is accepted when in_valid && in_ready.
- ACCUM, accepted beat with cnt==0:
  - acc <= in_data (direct load, no add against zero).
  - mode_q <= mode.
- ACCUM, accepted beat with cnt>0:
  - mode_q=0: acc[c] <= acc[c] + in[c], using the team FP adder (combinational, round-to-nearest-even).
  - mode_q=1: acc[c] <= max(acc[c], in[c]).
- Max compare: sign-magnitude ordering; +0 and -0 are equal; on equal, acc is kept. NaN/Inf inputs are out of scope and results for them are unspecified.
- Beat counting:
  - Each accepted beat: cnt <= cnt+1.
  - On the beat with cnt==N-1: cnt <= 0, and the next state is SCALE if mode_q==0, else OUTPUT.
  - For N==1, mode is taken from the current beat.
- SCALE (exactly 1 cycle): acc[c] <= acc[c] * RECIP via the team FP multiplier (combinational). Next state is OUTPUT.
- OUTPUT: hold acc and out_valid until out_ready. On out_valid && out_ready, go to ACCUM; the next beat may arrive the following cycle.
- Latency, last-beat edge k to out_valid high:
  - avg: out_valid high after edge k+1.
  - max: out_valid high after edge k.
- Frame throughput: one beat per cycle with no bubbles inside a frame. Avg frames have 2 dead cycles minimum, max frames 1.
- in_last check: on each accepted beat, if in_last != (cnt==N-1), pulse frame_err high for the cycle after that edge. Frame closure is driven by cnt only; in_last never alters cnt.
- in_valid while not in ACCUM: ignored; the beat is not consumed and the source must hold it.
- mode changes mid-frame are ignored until the next frame's first beat.
- Reset mid-frame or mid-OUTPUT: everything returns to reset values immediately, partial sums are discarded, and no result is emitted.
- Per-channel datapaths are independent; channel order is preserved exactly.

Test Plan:
All scenarios use CHANNELS=2, IMG_WIDTH=2, IMG_HEIGHT=2, RECIP=32'h3E800000 (0.25), unless stated otherwise.
- Avg frame: mode=0. ch0 = 1.0, 2.0, 3.0, 4.0; ch1 = -1.0 x4. Require out_data = {ch1=32'hBF800000, ch0=32'h40200000}, out_valid high 2 edges after the 4th beat, frame_err=0.
- Max frame: mode=1. ch0 = 1.0, 4.0, 2.0, 3.0; ch1 = -3.0, -0.5, -2.0, -8.0. Require ch0=32'h40800000, ch1=32'hBF000000, out_valid 1 edge after the last beat.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Require out_data stable, in_ready=0, held in_valid beats not consumed. Then raise out_ready: handshake, and the next frame is accepted the following cycle with correct results.
- Back-to-back frames with mode toggled mid-frame (avg then max, mode flipped on beat 2): each frame uses the mode from its own first beat; results as in the first two scenarios.
- in_last asserted on beat 2 and deasserted on beat 4: frame_err pulses twice. The result still emits after beat 4 with correct values.
- Reset asserted after beat 2 of a frame, then a full avg frame of all 2.0 (32'h40000000): require output 32'h40000000, with no contribution from pre-reset beats.

Source files
------------

// File: rtl/global_pool_engine.sv
// Global pooling stage for the CNN tail.
//
// Reduces a frame of IMG_WIDTH*IMG_HEIGHT pixel beats to one FP32 value per channel,
// either the average (sum scaled by RECIP) or the maximum, chosen by the mode bit that
// rides on the first beat of each frame.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mode       0 = average, 1 = max; sampled on the first beat of a frame
//   in_valid   input beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   in_data    CHANNELS x FP32, channel c at bits [c*32 +: 32]
//   in_last    source's end-of-frame marker; only compared against the beat count
//   out_valid  per-channel result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_data   CHANNELS x FP32 result, same packing as in_data
//   frame_err  one-cycle pulse after a beat whose in_last disagrees with the count
//
// DATA_WIDTH must be 32 (IEEE-754 single). NaN/Inf inputs give unspecified results.
module global_pool_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 7,
  parameter int unsigned IMG_WIDTH  = 44,
  parameter int unsigned IMG_HEIGHT = 44,
  parameter logic [31:0] RECIP      = 32'h3A0767AB
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           frame_err
);

  localparam int unsigned N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {StAccum, StScale, StOutput} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CHANNELS-1:0][31:0]  acc_q, acc_d;
  logic                       mode_q, mode_d;
  logic                       frame_err_q, frame_err_d;

  logic [CHANNELS-1:0][31:0]  in_ch;
  logic                       beat_acc;
  logic                       last_beat;
  logic                       eff_mode;

  // ---------------------------------------------------------------------------
  // FP32 add, round-to-nearest-even. Operands are ordered by magnitude so the
  // subtraction never goes negative; 3 extra LSBs hold guard/round/sticky.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [27:0] mx, my, s, mask;
    logic [23:0] sig;
    logic [30:0] mag;
    logic        rnd;
    int          ex, ey, d;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    mx = {1'b0, (x[30:23] != 8'd0), x[22:0], 3'b000};
    my = {1'b0, (y[30:23] != 8'd0), y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 27) begin
      my = {27'd0, |my};
    end else if (d > 0) begin
      mask = (28'd1 << d) - 28'd1;
      my   = (my >> d) | {27'd0, |(my & mask)};
    end
    if (x[31] == y[31]) s = mx + my;
    else                s = mx - my;
    // Carry out of the hidden bit: renormalise right, keeping the sticky.
    if (s[27]) begin
      s  = {1'b0, s[27:2], s[1] | s[0]};
      ex = ex + 1;
    end
    // Cancellation: renormalise left, stopping at the denormal exponent.
    for (int i = 0; i < 26; i++) begin
      if (!s[26] && ex > 1) begin
        s  = s << 1;
        ex = ex - 1;
      end
    end
    if (s == 28'd0) begin
      // Exact cancellation gives +0; only -0 + -0 stays negative.
      res = {x[31] & y[31], 31'd0};
    end else begin
      sig = s[26:3];
      rnd = s[2] & (s[1] | s[0] | sig[0]);
      // Hidden bit carries into the exponent field, so denormals and
      // rounding overflow into the next binade fall out of one add.
      mag = (31'(ex - 1) << 23) + {7'd0, sig} + {30'd0, rnd};
      if (ex >= 255 || mag >= 31'h7F800000) res = {x[31], 8'hFF, 23'd0};
      else                                  res = {x[31], mag};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FP32 multiply, round-to-nearest-even. The product's leading one is brought
  // to bit 47; e is the biased exponent that bit 47 represents.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p, mask;
    logic [23:0] sig;
    logic [30:0] mag;
    logic [31:0] res;
    logic        sign, st, rnd;
    int          ea, eb, e, sh;
    sign = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) begin
      res = {sign, 31'd0};
    end else begin
      ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
      p  = {24'd0, (a[30:23] != 8'd0), a[22:0]} * {24'd0, (b[30:23] != 8'd0), b[22:0]};
      e  = ea + eb - 126;
      for (int i = 0; i < 47; i++) begin
        if (!p[47] && e > 1) begin
          p = p << 1;
          e = e - 1;
        end
      end
      st = 1'b0;
      if (e < 1) begin
        // Underflow into the denormal range.
        sh = 1 - e;
        e  = 1;
        if (sh >= 48) begin
          st = |p;
          p  = '0;
        end else begin
          mask = (48'd1 << sh) - 48'd1;
          st   = |(p & mask);
          p    = p >> sh;
        end
      end
      sig = p[47:24];
      rnd = p[23] & (st | (|p[22:0]) | sig[0]);
      mag = (31'(e - 1) << 23) + {7'd0, sig} + {30'd0, rnd};
      if (e >= 255 || mag >= 31'h7F800000) res = {sign, 8'hFF, 23'd0};
      else                                 res = {sign, mag};
    end
    return res;
  endfunction

  // Sign-magnitude "a > b" with +0 == -0.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic gt;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) gt = 1'b0;
    else if (a[31] != b[31])                  gt = b[31];
    else if (!a[31])                          gt = a[30:0] > b[30:0];
    else                                      gt = a[30:0] < b[30:0];
    return gt;
  endfunction

  // ---------------------------------------------------------------------------
  // Control and datapath
  // ---------------------------------------------------------------------------
  assign in_ch     = in_data;
  assign in_ready  = (state_q == StAccum) && rst;
  assign beat_acc  = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(N - 1));
  // On a frame's first beat mode_q is stale; this matters when N == 1.
  assign eff_mode  = (cnt_q == '0) ? mode : mode_q;

  assign out_valid = (state_q == StOutput);
  assign out_data  = acc_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (beat_acc) begin
          frame_err_d = (in_last != last_beat);
          if (cnt_q == '0) begin
            acc_d  = in_ch;
            mode_d = mode;
          end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
              if (mode_q) acc_d[c] = fp_gt(in_ch[c], acc_q[c]) ? in_ch[c] : acc_q[c];
              else        acc_d[c] = fp_add(acc_q[c], in_ch[c]);
            end
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = eff_mode ? StOutput : StScale;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StScale: begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          acc_d[c] = fp_mul(acc_q[c], RECIP);
        end
        state_d = StOutput;
      end
      StOutput: begin
        if (out_ready) state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StAccum;
      cnt_q       <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
